// File: rtl/deser_pkg.sv
// Shared types and helpers for the flexible-width serial-to-parallel converter.
package deser_pkg;

    localparam int DESER_W_DFLT = 16;
    localparam int LEN_W        = $clog2(DESER_W_DFLT + 1);

    typedef logic [LEN_W-1:0] len_t;

    // Accumulator slot for received bit k of a word that is word_len bits long.
    function automatic int bit_pos(input int k, input int word_len, input bit msb_first);
        return msb_first ? (word_len - 1 - k) : k;
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-entry valid/ready output register; flags a completed word that arrives while full and stalled.
module deser_out_reg #(
    parameter int W  = 16,
    parameter int LW = 5
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          load_i,
    input  logic [W-1:0]  data_i,
    input  logic [LW-1:0] len_i,
    input  logic          ready_i,
    output logic          val_o,
    output logic [W-1:0]  data_o,
    output logic [LW-1:0] len_o,
    output logic          overflow_o
);

    logic          val_q;
    logic [W-1:0]  data_q;
    logic [LW-1:0] len_q;
    logic          overflow_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            val_q      <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= load_i && val_q && !ready_i;
            if (load_i && (!val_q || ready_i)) begin
                val_q  <= 1'b1;
                data_q <= data_i;
                len_q  <= len_i;
            end else if (val_q && ready_i) begin
                val_q <= 1'b0;
            end
        end
    end

    assign val_o      = val_q;
    assign data_o     = data_q;
    assign len_o      = len_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/flex_deserializer.sv
// Serial-to-parallel converter with per-word length, flush of partial words and a 1-entry output stage.
module flex_deserializer
    import deser_pkg::*;
#(
    parameter int DESER_W   = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         srst_i,
    input  logic                         data_val_i,
    input  logic                         data_i,
    input  logic [$clog2(DESER_W+1)-1:0] len_i,
    input  logic                         flush_i,
    output logic                         deser_data_val_o,
    input  logic                         deser_data_ready_i,
    output logic [DESER_W-1:0]           deser_data_o,
    output logic [$clog2(DESER_W+1)-1:0] deser_len_o,
    output logic                         overflow_o
);

    localparam int LW = $clog2(DESER_W + 1);

    logic [LW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      word_len_q;
    logic [DESER_W-1:0] acc_q, acc_d;
    logic [LW-1:0]      len_sat, eff_len;
    logic [DESER_W-1:0] emit_data;
    logic               complete, flush_go, emit;
    int                 pos;

    always_comb begin
        len_sat = len_i;
        if (len_i == '0 || len_i > LW'(DESER_W))
            len_sat = LW'(DESER_W);
        eff_len = (cnt_q == '0) ? len_sat : word_len_q;
        pos     = bit_pos(int'(cnt_q), int'(eff_len), MSB_FIRST);

        acc_d = acc_q;
        if (data_val_i) begin
            for (int i = 0; i < DESER_W; i++)
                if (i == pos) acc_d[i] = data_i;
        end
        cnt_d = cnt_q + {{(LW-1){1'b0}}, data_val_i};

        complete = data_val_i && (cnt_d == eff_len);
        flush_go = flush_i && (cnt_d != '0);
        emit     = complete || flush_go;
        // MSB-first partial words are packed from the top of word_len; shift them down to bit 0.
        emit_data = MSB_FIRST ? (acc_d >> (eff_len - cnt_d)) : acc_d;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q      <= '0;
            word_len_q <= '0;
            acc_q      <= '0;
        end else begin
            if (data_val_i && cnt_q == '0)
                word_len_q <= len_sat;
            if (emit) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (data_val_i) begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
        end
    end

    deser_out_reg #(
        .W  (DESER_W),
        .LW (LW)
    ) u_out_reg (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .load_i     (emit),
        .data_i     (emit_data),
        .len_i      (cnt_d),
        .ready_i    (deser_data_ready_i),
        .val_o      (deser_data_val_o),
        .data_o     (deser_data_o),
        .len_o      (deser_len_o),
        .overflow_o (overflow_o)
    );

endmodule

// File: tb/tb_flex_deserializer.sv
// Directed bench: LSB-first and MSB-first instances driven by the same serial stimulus.
module tb_flex_deserializer;

    logic        clk = 1'b0;
    logic        srst, data_val, data_bit, flush, ready;
    logic [4:0]  len;
    logic        val_l, ovf_l, val_m, ovf_m;
    logic [15:0] data_l, data_m;
    logic [4:0]  len_l, len_m;

    int n_vec = 0;
    int n_bad = 0;
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    flex_deserializer #(.DESER_W(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .srst_i(srst), .data_val_i(data_val), .data_i(data_bit),
        .len_i(len), .flush_i(flush), .deser_data_val_o(val_l),
        .deser_data_ready_i(ready), .deser_data_o(data_l), .deser_len_o(len_l),
        .overflow_o(ovf_l));

    flex_deserializer #(.DESER_W(16), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .srst_i(srst), .data_val_i(data_val), .data_i(data_bit),
        .len_i(len), .flush_i(flush), .deser_data_val_o(val_m),
        .deser_data_ready_i(ready), .deser_data_o(data_m), .deser_len_o(len_m),
        .overflow_o(ovf_m));

    always @(negedge clk) if (ovf_l === 1'b1) ovf_cnt++;

    typedef struct {
        logic [15:0] bits;     // bit k = k-th serial bit
        int          nbits;
        logic [4:0]  len;
        bit          flush;    // flush on the last bit
        bit          msb;      // check the MSB-first instance
        bit          gap;      // idle cycle between bits
        logic [15:0] exp_data;
        logic [4:0]  exp_len;
    } row_t;

    row_t rows[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic [4:0] l, input logic fl);
        data_val = 1'b1;
        data_bit = b;
        len      = l;
        flush    = fl;
        @(negedge clk);
        data_val = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] bits, input int n, input logic [4:0] l);
        for (int k = 0; k < n; k++) send_bit(bits[k], l, 1'b0);
    endtask

    initial begin
        int ov0;
        logic [15:0] b;

        rows[0] = '{16'hA5C3, 16, 5'd16, 1'b0, 1'b0, 1'b0, 16'hA5C3, 5'd16};
        rows[1] = '{16'h004D,  8, 5'd8,  1'b0, 1'b1, 1'b0, 16'h00B2, 5'd8};
        rows[2] = '{16'h0003,  3, 5'd8,  1'b1, 1'b0, 1'b0, 16'h0003, 5'd3};
        rows[3] = '{16'h0003,  3, 5'd8,  1'b1, 1'b1, 1'b0, 16'h0006, 5'd3};
        rows[4] = '{16'h1234, 16, 5'd0,  1'b0, 1'b0, 1'b0, 16'h1234, 5'd16};
        rows[5] = '{16'h0001, 16, 5'd20, 1'b0, 1'b1, 1'b0, 16'h8000, 5'd16};
        rows[6] = '{16'h0001,  1, 5'd1,  1'b0, 1'b0, 1'b0, 16'h0001, 5'd1};
        rows[7] = '{16'h000D,  4, 5'd4,  1'b0, 1'b0, 1'b1, 16'h000D, 5'd4};
        rows[8] = '{16'h000A,  4, 5'd4,  1'b1, 1'b0, 1'b0, 16'h000A, 5'd4};
        rows[9] = '{16'h0001,  4, 5'd4,  1'b0, 1'b1, 1'b1, 16'h0008, 5'd4};

        srst = 1'b1; data_val = 1'b0; data_bit = 1'b0; flush = 1'b0;
        ready = 1'b1; len = 5'd16;
        @(negedge clk);
        @(negedge clk);
        chk("rst_val_l", {31'd0, val_l}, 32'd0);
        chk("rst_data_l", {16'd0, data_l}, 32'd0);
        chk("rst_len_l", {27'd0, len_l}, 32'd0);
        chk("rst_ovf_l", {31'd0, ovf_l}, 32'd0);
        chk("rst_val_m", {31'd0, val_m}, 32'd0);
        chk("rst_data_m", {16'd0, data_m}, 32'd0);
        chk("rst_len_m", {27'd0, len_m}, 32'd0);
        chk("rst_ovf_m", {31'd0, ovf_m}, 32'd0);
        srst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < rows[r].nbits; k++) begin
                b = rows[r].bits;
                send_bit(b[k], rows[r].len, rows[r].flush && (k == rows[r].nbits - 1));
                if (rows[r].gap && k < rows[r].nbits - 1) @(negedge clk);
            end
            chk($sformatf("row%0d_val", r), {31'd0, rows[r].msb ? val_m : val_l}, 32'd1);
            chk($sformatf("row%0d_data", r), {16'd0, rows[r].msb ? data_m : data_l},
                {16'd0, rows[r].exp_data});
            chk($sformatf("row%0d_len", r), {27'd0, rows[r].msb ? len_m : len_l},
                {27'd0, rows[r].exp_len});
            @(negedge clk);
            chk($sformatf("row%0d_val_drop", r), {31'd0, rows[r].msb ? val_m : val_l}, 32'd0);
        end

        // flush with nothing accumulated
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("empty_flush_l", {31'd0, val_l}, 32'd0);
        chk("empty_flush_m", {31'd0, val_m}, 32'd0);
        @(negedge clk);
        chk("empty_flush_l2", {31'd0, val_l}, 32'd0);

        // stalled output: second word dropped with one overflow pulse
        ready = 1'b0;
        ov0 = ovf_cnt;
        send_word(16'h0009, 4, 5'd4);
        chk("stall_w1_val", {31'd0, val_l}, 32'd1);
        chk("stall_w1_data", {16'd0, data_l}, 32'h9);
        chk("stall_w1_len", {27'd0, len_l}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            b = 16'h0006;
            send_bit(b[k], 5'd4, 1'b0);
            chk($sformatf("stall_hold%0d", k), {16'd0, data_l}, 32'h9);
        end
        chk("stall_ovf_pulse", {31'd0, ovf_l}, 32'd1);
        @(negedge clk);
        chk("stall_ovf_low", {31'd0, ovf_l}, 32'd0);
        chk("stall_ovf_count", ovf_cnt - ov0, 32'd1);
        chk("stall_still_val", {31'd0, val_l}, 32'd1);
        chk("stall_still_data", {16'd0, data_l}, 32'h9);
        chk("stall_still_len", {27'd0, len_l}, 32'd4);
        ready = 1'b1;
        @(negedge clk);
        chk("stall_drained", {31'd0, val_l}, 32'd0);

        // reset mid-word discards partial word without overflow
        ov0 = ovf_cnt;
        send_word(16'h001F, 5, 5'd16);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("midrst_val", {31'd0, val_l}, 32'd0);
        send_word(16'hBEEF, 16, 5'd16);
        chk("midrst_fresh_val", {31'd0, val_l}, 32'd1);
        chk("midrst_fresh_data", {16'd0, data_l}, 32'hBEEF);
        chk("midrst_fresh_len", {27'd0, len_l}, 32'd16);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_no_ovf", ovf_cnt - ov0, 32'd0);

        // len_i change mid-word only affects the next word
        b = 16'h00B1;
        send_bit(b[0], 5'd8, 1'b0);
        for (int k = 1; k < 4; k++) send_bit(b[k], 5'd4, 1'b0);
        chk("lenchg_no_early", {31'd0, val_l}, 32'd0);
        for (int k = 4; k < 8; k++) send_bit(b[k], 5'd4, 1'b0);
        chk("lenchg_w1_val", {31'd0, val_l}, 32'd1);
        chk("lenchg_w1_data", {16'd0, data_l}, 32'hB1);
        chk("lenchg_w1_len", {27'd0, len_l}, 32'd8);
        send_word(16'h000A, 4, 5'd4);
        chk("lenchg_w2_val", {31'd0, val_l}, 32'd1);
        chk("lenchg_w2_data", {16'd0, data_l}, 32'hA);
        chk("lenchg_w2_len", {27'd0, len_l}, 32'd4);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/flex_deserializer.md
FLEX_DESERIALIZER -- requirements
Module: flex_deserializer

Interface
REQ-001 Parameter DESER_W, default 16: maximum word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0: 0 places the first received bit at bit 0; 1 places the first received bit at bit len-1.
REQ-003 Port clk_i, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port srst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port data_val_i, input, 1: qualifies data_i for the current cycle.
REQ-006 Port data_i, input, 1: serial data bit.
REQ-007 Port len_i, input, $clog2(DESER_W+1): word length in bits, legal range 1..DESER_W.
REQ-008 Port flush_i, input, 1: requests emission of the partially assembled word.
REQ-009 Port deser_data_val_o, output, 1: output word valid.
REQ-010 Port deser_data_ready_i, input, 1: downstream accepts the output word.
REQ-011 Port deser_data_o, output, DESER_W: assembled word; bits at and above deser_len_o SHALL be 0.
REQ-012 Port deser_len_o, output, $clog2(DESER_W+1): number of valid bits in deser_data_o.
REQ-013 Port overflow_o, output, 1: one-cycle pulse when a completed word is dropped.

Function
REQ-014 The block SHALL latch len_i into word_len on the first accepted bit of each word (data_val_i=1 and bit count=0); a len_i of 0 or greater than DESER_W SHALL be treated as DESER_W.
REQ-015 Changes on len_i mid-word SHALL have no effect until the next word starts.
REQ-016 Accepted bit k (0-based) SHALL be written to accumulator position k when MSB_FIRST=0, and to position word_len-1-k when MSB_FIRST=1.
REQ-017 A word SHALL complete on the cycle its bit word_len-1 is accepted; the bit count and accumulator SHALL then clear to 0 on the next edge.
REQ-018 Output handshake: the word transfers when deser_data_val_o=1 and deser_data_ready_i=1 on the same edge.
REQ-019 The output register SHALL be loaded with a completed word when it is empty or transferring on that edge; deser_data_val_o SHALL then be 1 on the following cycle, giving a latency of 1 cycle after the last bit.
REQ-020 While deser_data_val_o=1 and deser_data_ready_i=0, deser_data_o and deser_len_o SHALL hold stable.
REQ-021 If a word completes while the output register is full and not transferring, the word SHALL be dropped, overflow_o SHALL pulse high for 1 cycle, and the accumulator SHALL still clear.
REQ-022 When flush_i=1 with at least one bit accumulated (including a bit accepted in the same cycle), the partial word SHALL be emitted under the REQ-019 and REQ-021 rules, with deser_len_o set to the bit count.
REQ-023 For a partial word with MSB_FIRST=1, the bits SHALL be right-aligned: the first bit lands at position count-1.
REQ-024 flush_i with no accumulated bits and no bit accepted in that cycle SHALL be ignored.
REQ-025 flush_i coinciding with word completion SHALL produce exactly one full-length word.
REQ-026 With data_val_i=0, the accumulator and bit count SHALL hold.

Reset
REQ-027 With srst_i=1, the following SHALL clear to 0 on the next edge: bit count, word_len, accumulator, deser_data_val_o, deser_data_o, deser_len_o, overflow_o.
REQ-028 Reset mid-word SHALL discard the partial word without asserting overflow_o.
REQ-029 srst_i SHALL take priority over all other inputs.

Structure
REQ-030 Package deser_pkg SHALL hold: the length typedef, the localparam LEN_W = $clog2(DESER_W+1), and the function that converts a bit index to an accumulator position.
REQ-031 The block SHALL contain one sub-module, deser_out_reg: the 1-entry valid/ready output register with the overflow detection.
REQ-032 The accumulator and counter SHALL live in flex_deserializer.

Verification
REQ-033 DESER_W=16, MSB_FIRST=0, len_i=16, ready=1, bits 0xA5C3 sent LSB-first -> deser_data_o=0xA5C3, deser_len_o=16, val high for 1 cycle, 1 cycle after the last bit.
REQ-034 MSB_FIRST=1, len_i=8, bits 1,0,1,1,0,0,1,0 -> deser_data_o=0x00B2, deser_len_o=8.
REQ-035 len_i=8, 3 bits 1,1,0 then flush_i -> deser_data_o=0x0003, deser_len_o=3; a later flush with no bits -> no output.
REQ-036 ready=0, two back-to-back 4-bit words -> first word held stable, overflow_o pulses once at the second word's completion; raising ready -> first word transfers.
REQ-037 srst_i asserted after 5 of 16 bits, then 16 fresh bits -> only the fresh word appears, overflow_o stays 0.
REQ-038 len_i changed from 8 to 4 mid-word -> the current word completes at 8 bits and the next word at 4 bits.
